mux_channel_scanner: RTL
========================

Name: mux_channel_scanner

Overview:
Parametrised successor to the basic 8:1 multiplexer. Selects one of CH input channels, each W bits wide, and drives it onto a registered output. Besides manual selection, it can scan the channels automatically, holding each channel for DWELL cycles, either continuously or as one sweep. Used as the front end for polling banks of status and input lines.

Parameters:
CH, 8, number of input channels (>=2; need not be a power of two)
W, 1, width of each channel in bits (>=1)
DWELL, 4, clock cycles spent on each channel in scan modes (>=1)
IW, $clog2(CH), index width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
din  input  CH*W  packed channels; channel c = din[c*W +: W]
sel  input  IW  manual channel select
mode  input  2  00 manual, 01 continuous scan, 10 single sweep, 11 treated as manual
start  input  1  begin scan (modes 01/10), sampled in IDLE only
stop  input  1  abort scan, return to IDLE
y  output  W  registered selected channel data
ch_idx  output  IW  index of the channel currently presented on y
valid  output  1  y/ch_idx hold a fresh sample this cycle
busy  output  1  high while in SCAN
done  output  1  one-cycle pulse at the end of a single sweep

Behaviour:
- Reset (async, any time, including mid-scan):
  - y=0, ch_idx=0, valid=0, busy=0, done=0.
  - state=IDLE, scan index=0, dwell count=0.
- States: IDLE, SCAN. Mode is latched at start; mode changes during SCAN are ignored.
- IDLE, manual (mode 00/11, or start low), every edge:
  - y<=din[sel], ch_idx<=sel, valid<=1. Latency 1 cycle.
  - If sel>=CH: y<=0, ch_idx<=sel, valid<=0.
- IDLE, start=1 with mode 01/10 and stop=0, at edge k:
  - state<=SCAN, idx<=0, dc<=0, busy<=1, valid<=0. y holds its value.
  - start and stop together: stop wins, stay IDLE (manual behaviour).
- SCAN, each edge:
  - If dc<DWELL-1: dc<=dc+1, valid<=0; y and ch_idx hold.
  - If dc==DWELL-1 (sample edge): y<=din[idx], ch_idx<=idx, valid<=1, dc<=0.
  - Channel c is therefore sampled at edge k+(c+1)*DWELL; valid is high for exactly one cycle per channel.
  - Index advance: idx<=idx+1, or 0 if idx==CH-1.
  - On the wrap in continuous mode: stay in SCAN.
  - On the wrap in single mode: done<=1 on the same edge as the last valid, state<=IDLE, busy<=0.
  - DWELL=1: a sample every edge, valid held high continuously.
- stop=1 in SCAN:
  - Next edge: state<=IDLE, busy<=0, valid<=0, done<=0. No sample is taken, even on a sample edge.
  - idx and dc clear.
- start while in SCAN is ignored.
- done is high for one cycle only and is never asserted in continuous mode or after stop.

Decomposition:
- Package mux_scan_pkg:
  - mode constants MODE_MANUAL=2'b00, MODE_CONT=2'b01, MODE_SINGLE=2'b10.
  - state encoding IDLE=1'b0, SCAN=1'b1.
- Sub-module dwell_timer(clk, rst, clr, en, tick):
  - counts 0..DWELL-1 and asserts tick at the terminal count.
  - Instantiated once; the top level owns the index counter and the FSM.

Test Plan:
1. CH=8, W=1, DWELL=4, din=8'b0000_1010, mode=00; sweep sel 0..7 every 10 cycles -> one cycle after each change y = 0,1,0,1,0,0,0,0, ch_idx=sel, valid=1.
2. Same din, mode=10, start pulse at edge k -> valid at k+4,k+8,...,k+32 with ch_idx 0..7 and y 0,1,0,1,0,0,0,0; done=1 only at the k+32 sample; busy low from k+33.
3. mode=01, run 20 samples -> ch_idx sequence 0..7,0..7,0..3; done never asserted; stop at the 21st sample edge -> valid=0, busy=0, IDLE.
4. CH=5, W=4, DWELL=1, din channels 4'h1..4'h5, mode=10 -> valid high for 5 consecutive cycles, y=1,2,3,4,5, idx wraps after 4, done with y=5; manual sel=6 -> y=0, valid=0.
5. Assert rst mid-scan (after 3 samples), asynchronously between edges -> all outputs 0 immediately; after release with start=0, the block is in manual mode.
6. start and stop together in IDLE -> stays IDLE; start during SCAN plus a mode change -> sample sequence unchanged.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared encodings for the multiplexed channel scanner.
package mux_scan_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic is_scan_mode(input logic [1:0] m);
        return (m == MODE_CONT) || (m == MODE_SINGLE);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-channel dwell counter: counts 0..DWELL-1 and ticks at the terminal count.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// CH:1 registered channel selector with manual, continuous-scan and
// single-sweep modes; the FSM and index counter live here.
module mux_channel_scanner
    import mux_scan_pkg::*;
#(
    parameter int CH    = 8,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int IW   = $clog2(CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH*W-1:0] din,
    input  logic [IW-1:0] sel,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic          stop,
    output logic [W-1:0]  y,
    output logic [IW-1:0] ch_idx,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    localparam logic [IW:0]   CH_W = (IW + 1)'(CH);
    localparam logic [IW-1:0] LAST = IW'(CH - 1);

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [1:0]    mode_q, mode_n;
    logic [W-1:0]  y_n;
    logic [IW-1:0] ch_n;
    logic          valid_n, busy_n, done_n;
    logic          clr, en, tick;

    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            mode_q <= MODE_MANUAL;
            y      <= '0;
            ch_idx <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            mode_q <= mode_n;
            y      <= y_n;
            ch_idx <= ch_n;
            valid  <= valid_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        mode_n  = mode_q;
        y_n     = y;
        ch_n    = ch_idx;
        valid_n = valid;
        busy_n  = busy;
        done_n  = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop && is_scan_mode(mode)) begin
                    state_n = SCAN;
                    mode_n  = mode;
                    idx_n   = '0;
                    clr     = 1'b1;
                    busy_n  = 1'b1;
                    valid_n = 1'b0;
                end else begin
                    busy_n = 1'b0;
                    ch_n   = sel;
                    // Out-of-range selects read as zero and are flagged invalid.
                    if ({1'b0, sel} < CH_W) begin
                        y_n     = din[int'(sel)*W +: W];
                        valid_n = 1'b1;
                    end else begin
                        y_n     = '0;
                        valid_n = 1'b0;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    clr     = 1'b1;
                    busy_n  = 1'b0;
                    valid_n = 1'b0;
                end else begin
                    en      = 1'b1;
                    valid_n = 1'b0;
                    if (tick) begin
                        y_n     = din[int'(idx)*W +: W];
                        ch_n    = idx;
                        valid_n = 1'b1;
                        if (idx == LAST) begin
                            idx_n = '0;
                            if (mode_q == MODE_SINGLE) begin
                                done_n  = 1'b1;
                                state_n = IDLE;
                                busy_n  = 1'b0;
                            end
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
